roi_axis_crop: RTL
==================

Name: roi_axis_crop

Overview:
- Parametrised successor to the single-channel ROI extractor: crops a rectangular region of interest from an AXI4-Stream video frame.
- Multi-channel pixels, runtime frame size, full tvalid/tready backpressure, AXI-video SOF/EOL sideband.
- ROI corners are normalised (any corner order), latched per frame at SOF and validated against the frame size.
- Sits between the sensor/video source stream and downstream processing.

Parameters:
MAX_WIDTH, 2048, largest supported frame width in pixels
MAX_HEIGHT, 2048, largest supported frame height in lines
CHANNELS, 3, channels per pixel
BIT_CHAN, 8, bits per channel
BIT_COORD, 32, coordinate word width; x in [31:16], y in [15:0]

Ports:
clk_i  in  1  clock
arst_ni  in  1  asynchronous active-low reset
s_tdata_i  in  CHANNELS*BIT_CHAN  input pixel
s_tvalid_i  in  1  input valid
s_tready_o  out  1  input ready
s_tuser_i  in  1  start of frame, first pixel
s_tlast_i  in  1  end of input line
frame_w_i  in  16  active frame width, 1..MAX_WIDTH
frame_h_i  in  16  active frame height, 1..MAX_HEIGHT
xy_0_i  in  BIT_COORD  ROI corner A, inclusive
xy_1_i  in  BIT_COORD  ROI corner B, inclusive
m_tdata_o  out  CHANNELS*BIT_CHAN  cropped pixel
m_tvalid_o  out  1  output valid
m_tready_i  in  1  output ready
m_tuser_o  out  1  first ROI pixel of frame
m_tlast_o  out  1  last pixel of ROI line (see Optional Feature)
roi_err_o  out  1  one-cycle pulse: latched ROI invalid
frame_done_o  out  1  one-cycle pulse: last input pixel of frame accepted

Behaviour:
- Reset (arst_ni low, async): state IDLE, counters 0. m_tvalid_o, m_tuser_o, m_tlast_o, roi_err_o and frame_done_o are 0; m_tdata_o is 0. s_tready_o follows its equation (1 in reset).
- Handshakes:
  - in_hs = s_tvalid_i & s_tready_o.
  - s_tready_o = !m_tvalid_o | m_tready_i, combinational.
  - Output is a single register stage; latency is 1 cycle from the accepted ROI pixel to m_tvalid_o.
  - m_* are held stable while m_tvalid_o & !m_tready_i.
- Latching at SOF (in_hs & s_tuser_i):
  - xl=min(x0,x1), xr=max(x0,x1), yt=min(y0,y1), yb=max(y0,y1).
  - Frame size is also latched; x=0, y=0 for this pixel.
- Validity: valid iff xr < frame_w and yb < frame_h. If invalid, roi_err_o pulses on the cycle after SOF.
- States:
  - IDLE: accept and discard pixels. SOF -> ACTIVE if the ROI is valid, else SKIP.
  - ACTIVE: on every in_hs, the pixel is inside iff xl<=x<=xr and yt<=y<=yb. Inside pixels load the output register; outside pixels are dropped.
  - SKIP: consume pixels, output nothing.
  - From ACTIVE or SKIP, frame end -> IDLE, with frame_done_o pulsing one cycle after the last in_hs.
- Counters:
  - x increments per in_hs.
  - On s_tlast_i, or x==frame_w-1, x wraps to 0 and y increments; whichever comes first wins.
  - Frame end = wrap with y==frame_h-1.
  - Counter widths are $clog2(MAX_WIDTH) and $clog2(MAX_HEIGHT); no overflow is possible within the latched size.
- Sideband:
  - m_tuser_o=1 with pixel (xl,yt).
  - m_tlast_o=1 with pixel (xr,y) for every ROI row.
- SOF mid-frame (ACTIVE or SKIP): abort the current frame, relatch coords and frame size, restart at x=0,y=0. frame_done_o does not pulse for the aborted frame. A pending output pixel is still delivered.
- xy/frame_* changes outside SOF have no effect until the next SOF.
- Single-pixel ROI (xl==xr, yt==yb): one beat with m_tuser_o=1 and m_tlast_o=1.

Optional Feature:
- Macro ROI_FRAME_LAST_EN.
- Defined: m_tlast_o asserts only on pixel (xr,yb), the final ROI pixel of the frame (packet-per-frame mode). m_tuser_o is unchanged.
- Undefined: m_tlast_o asserts at the end of every ROI line (AXI video EOL).

Test Plan:
- Corner order: frame 8x4, pixel value = y*8+x, xy_0=(2,1), xy_1=(4,2), m_tready_i=1 -> outputs 10,11,12,18,19,20. m_tuser_o on 10; m_tlast_o on 12 and 20 (macro on: only 20). frame_done_o after pixel 31.
- Swapped corners: xy_0=(4,2), xy_1=(2,1) -> identical output stream to the corner-order case.
- Backpressure: same frame, m_tready_i toggling 1,0,0,1 repeating -> same 6 beats, no loss or duplication. s_tready_o=0 whenever m_tvalid_o & !m_tready_i. m_tdata_o stable while stalled.
- Invalid ROI: xy_1=(8,2) on an 8x4 frame -> roi_err_o pulses once, no m_tvalid_o for the whole frame, frame_done_o still pulses.
- Mid-frame SOF: s_tuser_i reasserted at pixel 13 of frame 1 -> only 10,11,12 emitted from frame 1. Frame 2 cropped fully from the new SOF; one frame_done_o total.
- Reset mid-frame: arst_ni low while m_tvalid_o=1 -> m_tvalid_o=0 immediately, state IDLE. Pixels ignored until the next SOF.

Source files
------------

// File: rtl/roi_axis_crop.sv
// rtl/roi_axis_crop.sv - AXI4-Stream video ROI crop with per-frame latched, normalised corners.
// Optional ROI_FRAME_LAST_EN: m_tlast_o marks only the final ROI pixel of the frame.
module roi_axis_crop #(
  parameter int MAX_WIDTH  = 2048,
  parameter int MAX_HEIGHT = 2048,
  parameter int CHANNELS   = 3,
  parameter int BIT_CHAN   = 8,
  parameter int BIT_COORD  = 32
) (
  input  logic                         clk_i,
  input  logic                         arst_ni,
  input  logic [CHANNELS*BIT_CHAN-1:0] s_tdata_i,
  input  logic                         s_tvalid_i,
  output logic                         s_tready_o,
  input  logic                         s_tuser_i,
  input  logic                         s_tlast_i,
  input  logic [15:0]                  frame_w_i,
  input  logic [15:0]                  frame_h_i,
  input  logic [BIT_COORD-1:0]         xy_0_i,
  input  logic [BIT_COORD-1:0]         xy_1_i,
  output logic [CHANNELS*BIT_CHAN-1:0] m_tdata_o,
  output logic                         m_tvalid_o,
  input  logic                         m_tready_i,
  output logic                         m_tuser_o,
  output logic                         m_tlast_o,
  output logic                         roi_err_o,
  output logic                         frame_done_o
);

  localparam int DW = CHANNELS * BIT_CHAN;
  localparam int XW = $clog2(MAX_WIDTH);
  localparam int YW = $clog2(MAX_HEIGHT);
  localparam int HW = BIT_COORD / 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_SKIP   = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;
  logic [HW-1:0]   r_xl, r_xr, r_yt, r_yb;
  logic [15:0]     r_fw, r_fh;

  logic [DW-1:0]   r_m_tdata;
  logic            r_m_tvalid;
  logic            r_m_tuser;
  logic            r_m_tlast;
  logic            r_roi_err;
  logic            r_frame_done;

  logic            w_in_hs;
  logic            w_sof;
  logic [HW-1:0]   w_x0, w_y0, w_x1, w_y1;
  logic [HW-1:0]   w_xl_in, w_xr_in, w_yt_in, w_yb_in;
  logic            w_roi_ok;
  logic [HW-1:0]   w_xl, w_xr, w_yt, w_yb;
  logic [15:0]     w_fw, w_fh;
  logic [XW-1:0]   w_cx;
  logic [YW-1:0]   w_cy;
  logic [HW-1:0]   w_cxh, w_cyh;
  logic            w_wrap;
  logic            w_frame_end;
  logic            w_in_frame;
  logic            w_inside;
  logic            w_active;
  logic            w_load;
  logic            w_tuser_nxt;
  logic            w_tlast_nxt;
  logic            w_done_nxt;
  logic            w_err_nxt;

  assign s_tready_o = !r_m_tvalid | m_tready_i;
  assign w_in_hs    = s_tvalid_i & s_tready_o;
  assign w_sof      = w_in_hs & s_tuser_i;

  // Corner normalisation: any corner order yields the same rectangle.
  assign w_x0    = xy_0_i[BIT_COORD-1:HW];
  assign w_y0    = xy_0_i[HW-1:0];
  assign w_x1    = xy_1_i[BIT_COORD-1:HW];
  assign w_y1    = xy_1_i[HW-1:0];
  assign w_xl_in = (w_x0 < w_x1) ? w_x0 : w_x1;
  assign w_xr_in = (w_x0 < w_x1) ? w_x1 : w_x0;
  assign w_yt_in = (w_y0 < w_y1) ? w_y0 : w_y1;
  assign w_yb_in = (w_y0 < w_y1) ? w_y1 : w_y0;
  assign w_roi_ok = ({16'd0, w_xr_in} < {{HW{1'b0}}, frame_w_i}) &
                    ({16'd0, w_yb_in} < {{HW{1'b0}}, frame_h_i});

  // The SOF beat itself sits at (0,0) and is judged against the values being latched.
  assign w_xl = w_sof ? w_xl_in   : r_xl;
  assign w_xr = w_sof ? w_xr_in   : r_xr;
  assign w_yt = w_sof ? w_yt_in   : r_yt;
  assign w_yb = w_sof ? w_yb_in   : r_yb;
  assign w_fw = w_sof ? frame_w_i : r_fw;
  assign w_fh = w_sof ? frame_h_i : r_fh;
  assign w_cx = w_sof ? '0 : r_x;
  assign w_cy = w_sof ? '0 : r_y;
  assign w_cxh = HW'(w_cx);
  assign w_cyh = HW'(w_cy);

  assign w_wrap      = s_tlast_i | (16'(w_cx) == (w_fw - 16'd1));
  assign w_frame_end = w_wrap & (16'(w_cy) == (w_fh - 16'd1));
  assign w_in_frame  = w_sof | (r_state != S_IDLE);
  assign w_inside    = (w_cxh >= w_xl) & (w_cxh <= w_xr) &
                       (w_cyh >= w_yt) & (w_cyh <= w_yb);
  assign w_active    = w_sof ? w_roi_ok : (r_state == S_ACTIVE);

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_sof) begin
      if (w_frame_end) begin
        w_state_nxt = S_IDLE;
      end else if (w_roi_ok) begin
        w_state_nxt = S_ACTIVE;
      end else begin
        w_state_nxt = S_SKIP;
      end
    end else if (w_in_hs && (r_state != S_IDLE) && w_frame_end) begin
      w_state_nxt = S_IDLE;
    end
  end

  always_comb begin
    w_load      = w_in_hs & w_active & w_inside;
    w_tuser_nxt = (w_cxh == w_xl) & (w_cyh == w_yt);
`ifdef ROI_FRAME_LAST_EN
    w_tlast_nxt = (w_cxh == w_xr) & (w_cyh == w_yb);
`else
    w_tlast_nxt = (w_cxh == w_xr);
`endif
    w_done_nxt  = w_in_hs & w_in_frame & w_frame_end;
    w_err_nxt   = w_sof & !w_roi_ok;
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_x  <= '0;
      r_y  <= '0;
      r_xl <= '0;
      r_xr <= '0;
      r_yt <= '0;
      r_yb <= '0;
      r_fw <= '0;
      r_fh <= '0;
    end else begin
      if (w_sof) begin
        r_xl <= w_xl_in;
        r_xr <= w_xr_in;
        r_yt <= w_yt_in;
        r_yb <= w_yb_in;
        r_fw <= frame_w_i;
        r_fh <= frame_h_i;
      end
      if (w_in_hs && w_in_frame) begin
        r_x <= w_wrap ? '0 : (w_cx + XW'(1));
        if (w_frame_end) begin
          r_y <= '0;
        end else if (w_wrap) begin
          r_y <= w_cy + YW'(1);
        end else begin
          r_y <= w_cy;
        end
      end
    end
  end

  // Single output stage; in_hs already implies the stage is free or draining.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_m_tdata    <= '0;
      r_m_tvalid   <= 1'b0;
      r_m_tuser    <= 1'b0;
      r_m_tlast    <= 1'b0;
      r_roi_err    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_roi_err    <= w_err_nxt;
      r_frame_done <= w_done_nxt;
      if (w_load) begin
        r_m_tdata  <= s_tdata_i;
        r_m_tvalid <= 1'b1;
        r_m_tuser  <= w_tuser_nxt;
        r_m_tlast  <= w_tlast_nxt;
      end else if (m_tready_i) begin
        r_m_tvalid <= 1'b0;
        r_m_tuser  <= 1'b0;
        r_m_tlast  <= 1'b0;
      end
    end
  end

  assign m_tdata_o    = r_m_tdata;
  assign m_tvalid_o   = r_m_tvalid;
  assign m_tuser_o    = r_m_tuser;
  assign m_tlast_o    = r_m_tlast;
  assign roi_err_o    = r_roi_err;
  assign frame_done_o = r_frame_done;

endmodule
